// File: rtl/be_core_pkg.sv
// Shared definitions for the be_core accumulator processor: opcodes, FSM states
// and the operand-length decode helper.
package be_core_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_XCH = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_JC  = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_OPND,
        S_LOAD,
        S_STORE,
        S_HALT
    } state_t;

    function automatic logic op_has_operand(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_JMP) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/be_core_alu.sv
// Combinational ADD / XCH / SUB unit for be_core. Opcodes it does not handle pass A/B/C through.
// SUB exists only when BE_CORE_SUB_EN is defined; otherwise opcode 5 falls through as a NOP.
module be_core_alu
    import be_core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_c,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic          o_c
);

    logic [DW:0] w_sum;
    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + (DW+1)'(i_c);

`ifdef BE_CORE_SUB_EN
    // Top bit of the widened difference is the borrow out.
    logic [DW:0] w_diff;
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - (DW+1)'(i_c);
`endif

    always_comb begin
        o_a = i_a;
        o_b = i_b;
        o_c = i_c;
        case (i_op)
            OP_ADD: {o_c, o_a} = w_sum;
            OP_XCH: begin
                o_a = i_b;
                o_b = i_a;
            end
`ifdef BE_CORE_SUB_EN
            OP_SUB: {o_c, o_a} = w_diff;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/be_core.sv
// Parametrised accumulator core with a ready-stalled single-port memory bus.
// Define BE_CORE_SUB_EN to enable SUB on opcode 5 (otherwise a one-word NOP).
module be_core
    import be_core_pkg::*;
#(
    parameter int             DW       = 8,
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = AW'('hF0)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic [AW-1:0] addr,
    output logic          req,
    output logic          rw,
    input  logic          ready,
    output logic          halt
);

    state_t        r_state, w_next;
    logic [AW-1:0] r_pc, r_ar;
    // Only the opcode field of the instruction word is kept; upper bits have no effect.
    logic [2:0]    r_ir;
    logic [DW-1:0] r_a, r_b;
    logic          r_c;

    logic [DW-1:0] w_alu_a, w_alu_b;
    logic          w_alu_c;
    logic [AW-1:0] w_opnd, w_pc_inc;
    logic          w_alu_op;

    assign w_opnd   = data_in[AW-1:0];
    assign w_pc_inc = r_pc + AW'(1);
    assign w_alu_op = !op_has_operand(r_ir) && (r_ir != OP_HLT);
    assign data_out = r_a;

    be_core_alu #(.DW(DW)) u_alu (
        .i_op (r_ir),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_c  (r_c),
        .o_a  (w_alu_a),
        .o_b  (w_alu_b),
        .o_c  (w_alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (ready) w_next = S_EXEC;
            S_EXEC: begin
                if (op_has_operand(r_ir)) w_next = S_OPND;
                else if (r_ir == OP_HLT)  w_next = S_HALT;
                else                      w_next = S_FETCH;
            end
            S_OPND: begin
                if (ready) begin
                    if (r_ir == OP_LDA)      w_next = S_LOAD;
                    else if (r_ir == OP_STA) w_next = S_STORE;
                    else                     w_next = S_FETCH;
                end
            end
            S_LOAD, S_STORE: if (ready) w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        addr = r_pc;
        req  = 1'b0;
        rw   = 1'b0;
        halt = 1'b0;
        case (r_state)
            S_FETCH, S_OPND: req = 1'b1;
            S_LOAD: begin
                req  = 1'b1;
                addr = r_ar;
            end
            S_STORE: begin
                req  = 1'b1;
                rw   = 1'b1;
                addr = r_ar;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    // Datapath: every update is gated by the state and, on bus states, by ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ar <= '0;
            r_ir <= '0;
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (ready) begin
                        r_ir <= data_in[2:0];
                        r_pc <= w_pc_inc;
                    end
                end
                S_EXEC: begin
                    if (w_alu_op) begin
                        r_a <= w_alu_a;
                        r_b <= w_alu_b;
                        r_c <= w_alu_c;
                    end
                end
                S_OPND: begin
                    if (ready) begin
                        case (r_ir)
                            OP_LDA, OP_STA: begin
                                r_ar <= w_opnd;
                                r_pc <= w_pc_inc;
                            end
                            OP_JMP:  r_pc <= w_opnd;
                            OP_JC:   r_pc <= r_c ? w_opnd : w_pc_inc;
                            default: ;
                        endcase
                    end
                end
                S_LOAD: if (ready) r_a <= data_in;
                default: ;
            endcase
        end
    end

endmodule
